seq_shifter: RTL and testbench
==============================

# seq_shifter

Iterative, multi-cycle 16-bit shift unit that performs the opposite-direction shift operations to the single-cycle combinational barrel shifter: logical right shift, logical left shift and rotate-left. It shifts one position per cycle (four with the fast path) under a start/busy/done handshake. It sits beside the ALU as an off-critical-path shift engine for the control unit or microcode sequencer, where latency is acceptable in exchange for area.

## Interface
- WIDTH, 16, data path width; fixed at 16 for this ISA
- CNT_W, 4, shift-amount width, equal to log2(WIDTH)

- clk  input  1  single clock, rising-edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request; sampled only when busy=0
- data_in  input  WIDTH  operand, captured on accepted start
- shamt  input  CNT_W  shift amount 0..15, captured on accepted start
- mode  input  2  operation, captured on accepted start
  - 00=SRL
  - 01=SLL
  - 10=ROL
  - 11=ROL
- busy  output  1  high while in SHIFT
- done  output  1  one-cycle pulse, result valid
- data_out  output  WIDTH  result register; holds its value until the next done
- zero  output  1  data_out==0, updated together with data_out

## Operation
- FSM states:
  - IDLE
  - SHIFT
  - DONE
- Reset state is IDLE.
- Accept: start=1 and state is IDLE or DONE.
  - Load work_reg=data_in, cnt=shamt and op=mode.
  - Next state is SHIFT if shamt≠0, else DONE.
- SHIFT: each cycle, apply one step to work_reg and decrement cnt. Step by op:
  - SRL: {1'b0, w[15:1]}
  - SLL: {w[14:0], 1'b0}
  - ROL: {w[14:0], w[15]}
- When the step consumes the last count (cnt reaches 0), go to DONE. In the same edge, load data_out with the final work_reg and zero with (final==0).
- shamt=0 path: the accept edge goes to DONE and loads data_out=data_in and zero=(data_in==0).
- DONE: done=1 for exactly one cycle. Next state is SHIFT/DONE if a new start is accepted, else IDLE.
- start while busy=1 is ignored and has no side effects.
- data_in, shamt and mode changes after acceptance have no effect on the operation in flight.
- SRL/SLL by 15 leave exactly one surviving bit. ROL is modulo 16.

## Timing
- Outputs are registered.
- Reset values: busy=0, done=0, data_out=16'h0000, zero=0. Internal work_reg=0, cnt=0.
- Start high in cycle 0 (accepted) gives done=1 in cycle shamt+1. Also:
  - busy=1 in cycles 1..shamt
  - busy=0 in cycle 0 and in the DONE cycle
- shamt=0: done in cycle 1, busy never asserted.
- Back-to-back: start held high during the DONE cycle is accepted, so there is no idle bubble.
- rst_n low mid-operation asynchronously forces all reset values. The operation is abandoned and no done is produced. The first start after rst_n deasserts is accepted normally.

## Configuration
- SEQ_SHIFTER_NIBBLE_EN
  - Defined: in SHIFT, the step is 4 positions when cnt≥4, else 1 position.
    - 4-position steps: SRL {4'b0, w[15:4]}, SLL {w[11:0], 4'b0}, ROL {w[11:0], w[15:12]}.
    - cnt decrements by the step size.
    - done occurs in cycle floor(shamt/4) + (shamt mod 4) + 1; worst case is 7.
  - Not defined: strictly 1 position per cycle, worst-case done in cycle 16.
  - Results are bit-identical in both builds. Only latency and busy length differ.

## Test plan
- SRL: data_in=0x8001, shamt=4, mode=00 → data_out=0x0800, zero=0. done in cycle 5 (cycle 2 with NIBBLE_EN), single-cycle pulse.
- SLL and ROL:
  - SLL: 0x00FF, shamt=15, mode=01 → 0x8000, done in cycle 16 (7 with NIBBLE_EN).
  - ROL: 0x1234, shamt=8, mode=10 and mode=11 → 0x3412 both.
- Edges:
  - 0xA5A5, shamt=0 → 0xA5A5, done in cycle 1, busy never high.
  - SRL 0x0001 by 1 → 0x0000, zero=1.
  - ROL 0x8000 by 15 → 0x4000.
- Handshake:
  - start re-pulsed with different operands while busy → ignored, original result delivered.
  - start held through the DONE cycle → second operation accepted with no gap, second done in the expected cycle.
- Reset mid-operation: rst_n low in cycle 3 of a shamt=10 SLL → busy/done/data_out/zero go to 0/0/0x0000/0 immediately, no done follows. Next start (SRL 0xF000 by 12) → 0x000F.
- Operand stability: data_in, shamt and mode randomized every cycle after acceptance → data_out matches a reference model using the captured values only.

Source files
------------

// File: rtl/seq_shifter.sv
// Iterative 16-bit shift engine (SRL / SLL / ROL), one position per cycle.
// Define SEQ_SHIFTER_NIBBLE_EN to take 4-position steps while cnt >= 4.
module seq_shifter #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  input  logic [CNT_W-1:0] shamt,
  input  logic [1:0]       mode,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] data_out,
  output logic             zero,
  output logic [1:0]       state_dbg
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [1:0] OP_SRL = 2'b00;
  localparam logic [1:0] OP_SLL = 2'b01;

  logic [1:0]       state;
  logic [WIDTH-1:0] work_reg;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       op;

  logic             use_nib;
  logic [CNT_W-1:0] step_amt;
  logic [CNT_W-1:0] cnt_next;
  logic [WIDTH-1:0] work_next;
  logic             accept;

  // Handshake: start is honoured whenever the engine is not shifting (IDLE or
  // DONE); done is a one-cycle pulse qualifying data_out/zero; busy marks SHIFT.
  assign accept    = start && (state != ST_SHIFT);
  assign busy      = (state == ST_SHIFT);
  assign done      = (state == ST_DONE);
  assign state_dbg = state;

  always_comb begin
    use_nib = 1'b0;
`ifdef SEQ_SHIFTER_NIBBLE_EN
    use_nib = (cnt >= CNT_W'(4));
`endif
    step_amt = use_nib ? CNT_W'(4) : CNT_W'(1);
    cnt_next = cnt - step_amt;
    case (op)
      OP_SRL:  work_next = use_nib ? {4'b0, work_reg[WIDTH-1:4]}
                                   : {1'b0, work_reg[WIDTH-1:1]};
      OP_SLL:  work_next = use_nib ? {work_reg[WIDTH-5:0], 4'b0}
                                   : {work_reg[WIDTH-2:0], 1'b0};
      default: work_next = use_nib ? {work_reg[WIDTH-5:0], work_reg[WIDTH-1:WIDTH-4]}
                                   : {work_reg[WIDTH-2:0], work_reg[WIDTH-1]};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      work_reg <= '0;
      cnt      <= '0;
      op       <= OP_SRL;
      data_out <= '0;
      zero     <= 1'b0;
    end else if (accept) begin
      work_reg <= data_in;
      cnt      <= shamt;
      op       <= mode;
      if (shamt == '0) begin
        // Zero-length shift bypasses SHIFT and publishes the operand directly.
        state    <= ST_DONE;
        data_out <= data_in;
        zero     <= (data_in == '0);
      end else begin
        state <= ST_SHIFT;
      end
    end else begin
      case (state)
        ST_SHIFT: begin
          work_reg <= work_next;
          cnt      <= cnt_next;
          if (cnt_next == '0) begin
            state    <= ST_DONE;
            data_out <= work_next;
            zero     <= (work_next == '0);
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_shifter.sv
// Self-checking bench for seq_shifter: scoreboard of expected {zero,data_out}
// and done cycle, checked by a monitor whenever done pulses.
module tb_seq_shifter;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] data_in;
  logic [3:0]  shamt;
  logic [1:0]  mode;
  logic        busy;
  logic        done;
  logic [15:0] data_out;
  logic        zero;
  logic [1:0]  state_dbg;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  logic [16:0] exp_q[$];
  int          exp_cyc_q[$];

  seq_shifter dut (
    .clk(clk), .rst_n(rst_n), .start(start), .data_in(data_in),
    .shamt(shamt), .mode(mode), .busy(busy), .done(done),
    .data_out(data_out), .zero(zero), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  function automatic logic [15:0] ref_shift(logic [15:0] d, logic [3:0] s, logic [1:0] m);
    logic [31:0] dd;
    case (m)
      2'b00:   return d >> s;
      2'b01:   return d << s;
      default: begin
        dd = {d, d} << s;
        return dd[31:16];
      end
    endcase
  endfunction

  function automatic int latency(logic [3:0] s);
`ifdef SEQ_SHIFTER_NIBBLE_EN
    return int'(s) / 4 + int'(s) % 4 + 1;
`else
    return int'(s) + 1;
`endif
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [16:0] e;
    int          ec;
    if (rst_n && done) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_done: done=1 at cycle %0d, required no done", cyc);
      end else begin
        e  = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        if (data_out !== e[15:0]) begin
          n_fail++;
          $display("FAIL data_out: got %h, required %h", data_out, e[15:0]);
        end
        n_cmp++;
        if (zero !== e[16]) begin
          n_fail++;
          $display("FAIL zero: got %b, required %b", zero, e[16]);
        end
        n_cmp++;
        if (cyc !== ec) begin
          n_fail++;
          $display("FAIL done_cycle: got %0d, required %0d", cyc, ec);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_exp(logic [15:0] d, logic [3:0] s, logic [1:0] m);
    logic [15:0] r;
    r = ref_shift(d, s, m);
    exp_q.push_back({(r == 16'h0), r});
    exp_cyc_q.push_back(cyc + latency(s));
  endtask

  // Launch one operation from an idle engine, count busy cycles until done.
  task automatic run_op(logic [15:0] d, logic [3:0] s, logic [1:0] m, bit scramble);
    int bcnt;
    bcnt = 0;
    data_in = d; shamt = s; mode = m; start = 1'b1;
    push_exp(d, s, m);
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (exp_q.size() == 0) break;
      if (busy) bcnt++;
      if (scramble) begin
        data_in = 16'($urandom);
        shamt   = 4'($urandom_range(0, 15));
        mode    = 2'($urandom_range(0, 3));
      end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL done_timeout: op d=%h s=%0d m=%0d never completed", d, s, m);
      exp_q.delete(); exp_cyc_q.delete();
    end
    n_cmp++;
    if (bcnt != latency(s) - 1) begin
      n_fail++;
      $display("FAIL busy_len: got %0d busy cycles, required %0d", bcnt, latency(s) - 1);
    end
    n_cmp++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL done_pulse: done=%b the cycle after done, required 0", done);
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 60; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
      exp_q.delete(); exp_cyc_q.delete();
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; data_in = '0; shamt = '0; mode = '0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({busy, done, data_out, zero, state_dbg} !== 21'h0) begin
      n_fail++;
      $display("FAIL reset_values: busy=%b done=%b data_out=%h zero=%b state=%0d, required all 0",
               busy, done, data_out, zero, state_dbg);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_srl();
    run_op(16'h8001, 4'd4, 2'b00, 1'b0);
  endtask

  task automatic test_sll_rol();
    run_op(16'h00FF, 4'd15, 2'b01, 1'b0);
    run_op(16'h1234, 4'd8,  2'b10, 1'b0);
    run_op(16'h1234, 4'd8,  2'b11, 1'b0);
  endtask

  task automatic test_edges();
    run_op(16'hA5A5, 4'd0,  2'b01, 1'b0);
    run_op(16'h0001, 4'd1,  2'b00, 1'b0);
    run_op(16'h8000, 4'd15, 2'b10, 1'b0);
    run_op(16'h8000, 4'd15, 2'b00, 1'b0);
    run_op(16'hFFFF, 4'd15, 2'b01, 1'b0);
  endtask

  task automatic test_busy_ignore();
    data_in = 16'hC3C3; shamt = 4'd7; mode = 2'b10; start = 1'b1;
    push_exp(16'hC3C3, 4'd7, 2'b10);
    @(posedge clk); #1;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_after_accept: busy=%b, required 1", busy);
    end
    // Re-pulse with different operands while shifting.
    data_in = 16'h0000; shamt = 4'd1; mode = 2'b00; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_drain();
  endtask

  task automatic test_back_to_back();
    bit found;
    found = 1'b0;
    data_in = 16'h8001; shamt = 4'd4; mode = 2'b00; start = 1'b1;
    push_exp(16'h8001, 4'd4, 2'b00);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) begin found = 1'b1; break; end
    end
    n_cmp++;
    if (!found) begin
      n_fail++;
      $display("FAIL b2b_first_done: no done within bound, required one");
    end
    data_in = 16'h1234; shamt = 4'd8; mode = 2'b11;
    push_exp(16'h1234, 4'd8, 2'b11);
    @(posedge clk); #1;
    start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_no_bubble: busy=%b after DONE cycle, required 1", busy);
    end
    wait_drain();
  endtask

  task automatic test_reset_mid();
    bit seen;
    seen = 1'b0;
    data_in = 16'h5A5A; shamt = 4'd10; mode = 2'b01; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, done, data_out, zero} !== 19'h0) begin
      n_fail++;
      $display("FAIL reset_mid: busy=%b done=%b data_out=%h zero=%b, required 0/0/0000/0",
               busy, done, data_out, zero);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    n_cmp++;
    if (seen) begin
      n_fail++;
      $display("FAIL reset_abandon: done=1 after reset, required no done");
    end
    run_op(16'hF000, 4'd12, 2'b00, 1'b0);
  endtask

  task automatic test_stability();
    for (int k = 0; k < 10; k++)
      run_op(16'($urandom), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 1'b1);
  endtask

  initial begin
    test_reset();
    test_srl();
    test_sll_rol();
    test_edges();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    test_stability();
    repeat (3) @(posedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL leftover: %0d expected results never produced, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
